// File: rtl/aes_ct_collector.sv
// Ciphertext collector for the pipelined AES core. It tracks which pipeline slots are valid,
// captures each ciphertext after LATENCY edges, and throttles issue using FIFO credits.
module aes_ct_collector #(
  parameter int LATENCY = 11,
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     src_valid,
  input  logic [TAG_W-1:0]         src_tag,
  output logic                     src_ready,
  input  logic [127:0]             ct_in,
  output logic                     out_valid,
  output logic [127:0]             out_data,
  output logic [TAG_W-1:0]         out_tag,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   inflight
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [LATENCY-1:0] dl_valid;
  logic [TAG_W-1:0]   dl_tag [LATENCY];

  logic [127:0]       mem_data [DEPTH];
  logic [TAG_W-1:0]   mem_tag  [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  logic               issue;
  logic               cap;
  logic               pop;
  logic [CW:0]        credit_sum;

  assign issue = src_valid & src_ready;
  assign cap   = dl_valid[LATENCY-1];
  assign pop   = out_valid & out_ready;

  // Credits come from registered counters only, so a same-cycle pop never opens a slot early.
  assign credit_sum = {1'b0, inflight} + {1'b0, level};
  assign src_ready  = credit_sum < CREDITS;
  assign out_valid  = (level != '0);
  assign out_data   = mem_data[rd_ptr];
  assign out_tag    = mem_tag[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_valid <= '0;
    end else begin
      dl_valid[0] <= issue;
      for (int i = 1; i < LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
      end
    end
  end

  // Tags are only ever consumed alongside a set valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    dl_tag[0] <= src_tag;
    for (int i = 1; i < LATENCY; i++) begin
      dl_tag[i] <= dl_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      mem_data[wr_ptr] <= ct_in;
      mem_tag[wr_ptr]  <= dl_tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      inflight <= '0;
    end else begin
      if (cap) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({cap, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      case ({issue, cap})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
